ysyx_24100006_axi_xbar_nport: RTL and testbench

YSYX_24100006_AXI_XBAR_NPORT -- requirements
Module: ysyx_24100006_axi_xbar_nport

---
 rtl/ysyx_24100006_axi_pkg.sv | 29 ++
 rtl/ysyx_24100006_axi_addr_dec.sv | 25 ++
 rtl/ysyx_24100006_axi_xbar_nport.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ysyx_24100006_axi_xbar_nport.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared constants, state encodings and request payload for the N-port AXI crossbar.
package ysyx_24100006_axi_pkg;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned SW    = 3;
  localparam int unsigned STRBW = 4;
  localparam int unsigned RESPW = 2;
  localparam int unsigned IDXW  = 3;

  localparam logic [RESPW-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESPW-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESPW-1:0] RESP_DECERR = 2'b11;

  localparam logic [SW-1:0] SIZE_1B = 3'b000;
  localparam logic [SW-1:0] SIZE_2B = 3'b001;
  localparam logic [SW-1:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_ERR} wr_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [SW-1:0] size;
  } ax_req_t;

endpackage

// File: rtl/ysyx_24100006_axi_addr_dec.sv
// Combinational address decoder: lowest-index slave whose masked base matches wins.
module ysyx_24100006_axi_addr_dec
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int unsigned         N_SLV    = 3,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [N_SLV*AW-1:0] SLV_MASK = {32'hF800_0000, 32'hFFFF_F000, 32'hFFFF_0000}
) (
  input  logic [AW-1:0]   addr,
  output logic            hit,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (!hit && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit = 1'b1;
        idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/ysyx_24100006_axi_xbar_nport.sv
// 1-master to N-slave AXI crossbar with independent read/write FSMs and DECERR handling.
module ysyx_24100006_axi_xbar_nport
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int unsigned         N_SLV    = 3,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000},
  parameter logic [N_SLV*AW-1:0] SLV_MASK = {32'hF800_0000, 32'hFFFF_F000, 32'hFFFF_0000}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_awvalid,
  output logic                     m_awready,
  input  logic [AW-1:0]            m_awaddr,
  input  logic [LW-1:0]            m_awlen,
  input  logic [SW-1:0]            m_awsize,
  input  logic                     m_wvalid,
  output logic                     m_wready,
  input  logic [DW-1:0]            m_wdata,
  input  logic [STRBW-1:0]         m_wstrb,
  input  logic                     m_wlast,
  output logic                     m_bvalid,
  input  logic                     m_bready,
  output logic [RESPW-1:0]         m_bresp,
  input  logic                     m_arvalid,
  output logic                     m_arready,
  input  logic [AW-1:0]            m_araddr,
  input  logic [LW-1:0]            m_arlen,
  input  logic [SW-1:0]            m_arsize,
  output logic                     m_rvalid,
  input  logic                     m_rready,
  output logic [DW-1:0]            m_rdata,
  output logic [RESPW-1:0]         m_rresp,
  output logic                     m_rlast,
  output logic [N_SLV-1:0]         s_awvalid,
  input  logic [N_SLV-1:0]         s_awready,
  output logic [N_SLV*AW-1:0]      s_awaddr,
  output logic [N_SLV*LW-1:0]      s_awlen,
  output logic [N_SLV*SW-1:0]      s_awsize,
  output logic [N_SLV-1:0]         s_wvalid,
  input  logic [N_SLV-1:0]         s_wready,
  output logic [N_SLV*DW-1:0]      s_wdata,
  output logic [N_SLV*STRBW-1:0]   s_wstrb,
  output logic [N_SLV-1:0]         s_wlast,
  input  logic [N_SLV-1:0]         s_bvalid,
  output logic [N_SLV-1:0]         s_bready,
  input  logic [N_SLV*RESPW-1:0]   s_bresp,
  output logic [N_SLV-1:0]         s_arvalid,
  input  logic [N_SLV-1:0]         s_arready,
  output logic [N_SLV*AW-1:0]      s_araddr,
  output logic [N_SLV*LW-1:0]      s_arlen,
  output logic [N_SLV*SW-1:0]      s_arsize,
  input  logic [N_SLV-1:0]         s_rvalid,
  output logic [N_SLV-1:0]         s_rready,
  input  logic [N_SLV*DW-1:0]      s_rdata,
  input  logic [N_SLV*RESPW-1:0]   s_rresp,
  input  logic [N_SLV-1:0]         s_rlast,
  output logic [1:0]               access_fault
);

  rd_state_e        rd_state_q, rd_state_d;
  wr_state_e        wr_state_q, wr_state_d;
  ax_req_t          ar_q, ar_d, aw_q, aw_d;
  logic [N_SLV-1:0] rd_sel_q, rd_sel_d, wr_sel_q, wr_sel_d;
  logic [LW-1:0]    rd_beat_q, rd_beat_d;
  logic             rd_acked_q, rd_acked_d, wr_acked_q, wr_acked_d;
  logic             wr_wdone_q, wr_wdone_d;
  logic [1:0]       fault_q, fault_d;

  logic            rd_hit, wr_hit;
  logic [IDXW-1:0] rd_idx, wr_idx;
  logic            ar_fwd, r_fwd, aw_fwd, w_fwd, b_fwd;

  logic             sel_arready, sel_rvalid, sel_rlast;
  logic [DW-1:0]    sel_rdata;
  logic [RESPW-1:0] sel_rresp, sel_bresp;
  logic             sel_awready, sel_wready, sel_bvalid;

  ysyx_24100006_axi_addr_dec #(.N_SLV(N_SLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_rd_dec (
    .addr(m_araddr), .hit(rd_hit), .idx(rd_idx)
  );
  ysyx_24100006_axi_addr_dec #(.N_SLV(N_SLV), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)) u_wr_dec (
    .addr(m_awaddr), .hit(wr_hit), .idx(wr_idx)
  );

  // Slave-to-master return mux driven by the latched one-hot selects.
  always_comb begin
    sel_arready = 1'b0; sel_rvalid = 1'b0; sel_rlast = 1'b0;
    sel_rdata   = '0;   sel_rresp  = '0;
    sel_awready = 1'b0; sel_wready = 1'b0; sel_bvalid = 1'b0; sel_bresp = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (rd_sel_q[i]) begin
        sel_arready = s_arready[i];
        sel_rvalid  = s_rvalid[i];
        sel_rlast   = s_rlast[i];
        sel_rdata   = s_rdata[i*DW +: DW];
        sel_rresp   = s_rresp[i*RESPW +: RESPW];
      end
      if (wr_sel_q[i]) begin
        sel_awready = s_awready[i];
        sel_wready  = s_wready[i];
        sel_bvalid  = s_bvalid[i];
        sel_bresp   = s_bresp[i*RESPW +: RESPW];
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q; ar_d = ar_q; rd_sel_d = rd_sel_q;
    rd_beat_d  = rd_beat_q;  rd_acked_d = rd_acked_q;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0;
    ar_fwd = 1'b0; r_fwd = 1'b0;
    case (rd_state_q)
      R_IDLE: if (m_arvalid) begin
        ar_d       = '{addr: m_araddr, len: m_arlen, size: m_arsize};
        rd_sel_d   = rd_hit ? (N_SLV'(1) << rd_idx) : '0;
        rd_beat_d  = '0;
        rd_acked_d = 1'b0;
        rd_state_d = rd_hit ? R_ADDR : R_ERR;
      end
      R_ADDR: begin
        ar_fwd    = 1'b1;
        m_arready = sel_arready;
        if (sel_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        r_fwd    = 1'b1;
        m_rvalid = sel_rvalid;
        m_rdata  = sel_rdata;
        m_rresp  = sel_rresp;
        m_rlast  = sel_rlast;
        if (sel_rvalid && m_rready && sel_rlast) rd_state_d = R_IDLE;
      end
      R_ERR: begin
        // One-cycle address acknowledge, then arlen+1 DECERR beats.
        if (!rd_acked_q) begin
          m_arready  = 1'b1;
          rd_acked_d = 1'b1;
        end else begin
          m_rvalid = 1'b1;
          m_rresp  = RESP_DECERR;
          m_rlast  = (rd_beat_q == ar_q.len);
          if (m_rready) begin
            if (m_rlast) begin
              rd_state_d = R_IDLE;
              rd_beat_d  = '0;
            end else begin
              rd_beat_d = rd_beat_q + LW'(1);
            end
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q; aw_d = aw_q; wr_sel_d = wr_sel_q;
    wr_acked_d = wr_acked_q; wr_wdone_d = wr_wdone_q;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
    aw_fwd = 1'b0; w_fwd = 1'b0; b_fwd = 1'b0;
    case (wr_state_q)
      W_IDLE: if (m_awvalid) begin
        aw_d       = '{addr: m_awaddr, len: m_awlen, size: m_awsize};
        wr_sel_d   = wr_hit ? (N_SLV'(1) << wr_idx) : '0;
        wr_acked_d = 1'b0;
        wr_wdone_d = 1'b0;
        wr_state_d = wr_hit ? W_ADDR : W_ERR;
      end
      W_ADDR: begin
        aw_fwd    = 1'b1;
        m_awready = sel_awready;
        if (sel_awready) wr_state_d = W_DATA;
      end
      W_DATA: begin
        w_fwd    = 1'b1;
        m_wready = sel_wready;
        if (m_wvalid && sel_wready && m_wlast) wr_state_d = W_RESP;
      end
      W_RESP: begin
        b_fwd    = 1'b1;
        m_bvalid = sel_bvalid;
        m_bresp  = sel_bresp;
        if (sel_bvalid && m_bready) wr_state_d = W_IDLE;
      end
      W_ERR: begin
        // Acknowledge AW, sink the burst, then hold DECERR until accepted.
        if (!wr_acked_q) begin
          m_awready  = 1'b1;
          wr_acked_d = 1'b1;
        end else if (!wr_wdone_q) begin
          m_wready = 1'b1;
          if (m_wvalid && m_wlast) wr_wdone_d = 1'b1;
        end else begin
          m_bvalid = 1'b1;
          m_bresp  = RESP_DECERR;
          if (m_bready) wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Only the selected slot sees traffic; all others are held at zero.
  always_comb begin
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_rready = '0;
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
    s_wvalid  = '0; s_wdata  = '0; s_wstrb = '0; s_wlast  = '0; s_bready = '0;
    for (int i = 0; i < int'(N_SLV); i++) begin
      if (rd_sel_q[i] && ar_fwd) begin
        s_arvalid[i]           = 1'b1;
        s_araddr[i*AW +: AW]   = ar_q.addr;
        s_arlen[i*LW +: LW]    = ar_q.len;
        s_arsize[i*SW +: SW]   = ar_q.size;
      end
      if (rd_sel_q[i] && r_fwd) s_rready[i] = m_rready;
      if (wr_sel_q[i] && aw_fwd) begin
        s_awvalid[i]           = 1'b1;
        s_awaddr[i*AW +: AW]   = aw_q.addr;
        s_awlen[i*LW +: LW]    = aw_q.len;
        s_awsize[i*SW +: SW]   = aw_q.size;
      end
      if (wr_sel_q[i] && w_fwd) begin
        s_wvalid[i]                = m_wvalid;
        s_wdata[i*DW +: DW]        = m_wdata;
        s_wstrb[i*STRBW +: STRBW]  = m_wstrb;
        s_wlast[i]                 = m_wlast;
      end
      if (wr_sel_q[i] && b_fwd) s_bready[i] = m_bready;
    end
  end

  always_comb begin
    fault_d[0] = m_rvalid && m_rready && (m_rresp != RESP_OKAY);
    fault_d[1] = m_bvalid && m_bready && (m_bresp != RESP_OKAY);
  end

  assign access_fault = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      ar_q       <= '0;
      aw_q       <= '0;
      rd_sel_q   <= '0;
      wr_sel_q   <= '0;
      rd_beat_q  <= '0;
      rd_acked_q <= 1'b0;
      wr_acked_q <= 1'b0;
      wr_wdone_q <= 1'b0;
      fault_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      ar_q       <= ar_d;
      aw_q       <= aw_d;
      rd_sel_q   <= rd_sel_d;
      wr_sel_q   <= wr_sel_d;
      rd_beat_q  <= rd_beat_d;
      rd_acked_q <= rd_acked_d;
      wr_acked_q <= wr_acked_d;
      wr_wdone_q <= wr_wdone_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_xbar_nport.sv
// Self-checking bench for the N-port AXI crossbar: table-driven reads plus write, concurrency and reset sequences.
module tb_ysyx_24100006_axi_xbar_nport;
  import ysyx_24100006_axi_pkg::*;

  localparam int unsigned N = 3;
  localparam logic [N*32-1:0] BASE = {32'h8000_0000, 32'h1000_0000, 32'h0200_0000};
  localparam logic [N*32-1:0] MASK = {32'hF800_0000, 32'hFFFF_F000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic reset;
  logic m_awvalid, m_awready; logic [31:0] m_awaddr; logic [7:0] m_awlen; logic [2:0] m_awsize;
  logic m_wvalid, m_wready; logic [31:0] m_wdata; logic [3:0] m_wstrb; logic m_wlast;
  logic m_bvalid, m_bready; logic [1:0] m_bresp;
  logic m_arvalid, m_arready; logic [31:0] m_araddr; logic [7:0] m_arlen; logic [2:0] m_arsize;
  logic m_rvalid, m_rready; logic [31:0] m_rdata; logic [1:0] m_rresp; logic m_rlast;
  logic [N-1:0] s_awvalid, s_awready; logic [N*32-1:0] s_awaddr; logic [N*8-1:0] s_awlen; logic [N*3-1:0] s_awsize;
  logic [N-1:0] s_wvalid, s_wready; logic [N*32-1:0] s_wdata; logic [N*4-1:0] s_wstrb; logic [N-1:0] s_wlast;
  logic [N-1:0] s_bvalid, s_bready; logic [N*2-1:0] s_bresp;
  logic [N-1:0] s_arvalid, s_arready; logic [N*32-1:0] s_araddr; logic [N*8-1:0] s_arlen; logic [N*3-1:0] s_arsize;
  logic [N-1:0] s_rvalid, s_rready; logic [N*32-1:0] s_rdata; logic [N*2-1:0] s_rresp; logic [N-1:0] s_rlast;
  logic [1:0] access_fault;

  logic [31:0] dec_addr; logic dec_hit; logic [2:0] dec_idx;

  int checks = 0;
  int errors = 0;
  int fault_rd = 0;
  int fault_wr = 0;

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
  rbeat_t r_exp_q[$];

  typedef struct { logic [31:0] addr; logic [7:0] len; int slot; logic [1:0] slv_resp; } rd_vec_t;
  rd_vec_t rv[4];

  always #5 clk = ~clk;

  ysyx_24100006_axi_xbar_nport #(.N_SLV(N), .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .clk(clk), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .access_fault(access_fault)
  );

  // Overlapping windows: slot 0 and slot 1 both claim 0x8xxx_xxxx.
  ysyx_24100006_axi_addr_dec #(
    .N_SLV(3),
    .SLV_BASE({32'h1000_0000, 32'h8000_0000, 32'h8000_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000})
  ) u_ovl (.addr(dec_addr), .hit(dec_hit), .idx(dec_idx));

  always @(negedge clk) begin
    if (access_fault[0]) fault_rd++;
    if (access_fault[1]) fault_wr++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ {24'hC0FFEE, 8'(b)};
  endfunction

  task automatic do_read(input rd_vec_t v);
    logic [N-1:0] oh; int f0; rbeat_t e; logic [1:0] er; int nfault;
    oh     = (v.slot < 0) ? N'(0) : (N'(1) << v.slot);
    er     = (v.slot < 0) ? RESP_DECERR : v.slv_resp;
    nfault = (v.slot < 0 || v.slv_resp != RESP_OKAY) ? int'(v.len) + 1 : 0;
    f0     = fault_rd;
    @(negedge clk);
    m_arvalid = 1'b1; m_araddr = v.addr; m_arlen = v.len; m_arsize = SIZE_4B;
    #1;
    chk("rd_idle_arready", m_arready, 0);
    chk("rd_same_cycle_s_arvalid", s_arvalid, 0);
    @(negedge clk);
    m_araddr = ~v.addr;
    #1;
    chk("s_arvalid_onehot", s_arvalid, oh);
    if (v.slot >= 0) begin
      chk("s_araddr_latched", s_araddr[v.slot*32 +: 32], v.addr);
      chk("s_arlen", s_arlen[v.slot*8 +: 8], v.len);
      chk("s_arsize", s_arsize[v.slot*3 +: 3], SIZE_4B);
      s_arready[v.slot] = 1'b1;
      #1;
    end
    chk("m_arready", m_arready, 1);
    @(negedge clk);
    m_arvalid = 1'b0; m_araddr = '0; s_arready = '0;
    for (int b = 0; b <= int'(v.len); b++) begin
      e.data = (v.slot < 0) ? 32'h0 : beat_data(v.addr, b);
      e.resp = er;
      e.last = (b == int'(v.len));
      r_exp_q.push_back(e);
    end
    m_rready = 1'b1;
    for (int b = 0; b <= int'(v.len); b++) begin
      if (v.slot >= 0) begin
        s_rvalid = oh;
        s_rdata[v.slot*32 +: 32] = beat_data(v.addr, b);
        s_rresp[v.slot*2 +: 2]   = v.slv_resp;
        s_rlast = (b == int'(v.len)) ? oh : N'(0);
      end
      #1;
      chk("m_rvalid", m_rvalid, 1);
      chk("s_rready", s_rready, oh);
      if (m_rvalid && r_exp_q.size() > 0) begin
        e = r_exp_q.pop_front();
        chk("m_rdata", m_rdata, e.data);
        chk("m_rresp", m_rresp, e.resp);
        chk("m_rlast", m_rlast, e.last);
      end
      @(negedge clk);
    end
    m_rready = 1'b0; s_rvalid = '0; s_rlast = '0; s_rdata = '0; s_rresp = '0;
    chk("rd_scoreboard_empty", r_exp_q.size(), 0);
    r_exp_q.delete();
    @(negedge clk);
    #1;
    chk("rd_idle_rvalid", m_rvalid, 0);
    chk("rd_fault_count", fault_rd - f0, nfault);
  endtask

  task automatic do_write(input logic [31:0] addr, input int nb, input int slot);
    logic [N-1:0] oh; int f0; logic [31:0] d;
    oh = (slot < 0) ? N'(0) : (N'(1) << slot);
    f0 = fault_wr;
    @(negedge clk);
    m_awvalid = 1'b1; m_awaddr = addr; m_awlen = 8'(nb - 1); m_awsize = SIZE_2B;
    #1;
    chk("wr_idle_awready", m_awready, 0);
    chk("wr_idle_wready", m_wready, 0);
    @(negedge clk);
    m_awaddr = ~addr;
    #1;
    chk("s_awvalid_onehot", s_awvalid, oh);
    if (slot >= 0) begin
      chk("s_awaddr_latched", s_awaddr[slot*32 +: 32], addr);
      chk("s_awlen", s_awlen[slot*8 +: 8], 8'(nb - 1));
      chk("s_awsize", s_awsize[slot*3 +: 3], SIZE_2B);
      s_awready[slot] = 1'b1;
      #1;
    end
    chk("m_awready", m_awready, 1);
    chk("wr_addr_wready", m_wready, 0);
    @(negedge clk);
    m_awvalid = 1'b0; m_awaddr = '0; s_awready = '0;
    if (slot >= 0) s_wready = oh;
    for (int b = 0; b < nb; b++) begin
      d = beat_data(addr, b);
      m_wvalid = 1'b1; m_wdata = d; m_wstrb = 4'hF; m_wlast = (b == nb - 1);
      #1;
      chk("m_wready", m_wready, 1);
      chk("s_wvalid", s_wvalid, oh);
      if (slot >= 0) begin
        chk("s_wdata", s_wdata[slot*32 +: 32], d);
        chk("s_wstrb", s_wstrb[slot*4 +: 4], 4'hF);
        chk("s_wlast", s_wlast[slot], (b == nb - 1));
      end
      @(negedge clk);
    end
    m_wvalid = 1'b0; m_wdata = '0; m_wlast = 1'b0; m_wstrb = '0; s_wready = '0;
    #1;
    chk("wr_resp_wready", m_wready, 0);
    if (slot >= 0) begin
      chk("b_before_slave", m_bvalid, 0);
      s_bvalid = oh; s_bresp[slot*2 +: 2] = RESP_OKAY;
      #1;
      chk("s_bready_low", s_bready, 0);
    end
    chk("m_bvalid", m_bvalid, 1);
    chk("m_bresp", m_bresp, (slot < 0) ? RESP_DECERR : RESP_OKAY);
    @(negedge clk);
    #1;
    chk("m_bvalid_held", m_bvalid, 1);
    chk("m_bresp_held", m_bresp, (slot < 0) ? RESP_DECERR : RESP_OKAY);
    m_bready = 1'b1;
    #1;
    chk("s_bready", s_bready, oh);
    @(negedge clk);
    m_bready = 1'b0; s_bvalid = '0; s_bresp = '0;
    @(negedge clk);
    #1;
    chk("wr_idle_bvalid", m_bvalid, 0);
    chk("wr_fault_count", fault_wr - f0, (slot < 0) ? 1 : 0);
  endtask

  initial begin
    rv[0] = '{32'h8000_0010, 8'd3, 2,  RESP_OKAY};
    rv[1] = '{32'h3000_0000, 8'd1, -1, RESP_OKAY};
    rv[2] = '{32'h0200_BFF8, 8'd0, 0,  RESP_OKAY};
    rv[3] = '{32'h1000_0FFC, 8'd2, 1,  RESP_SLVERR};

    reset = 1'b0;
    m_awvalid = 0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
    m_wvalid = 0; m_wdata = '0; m_wstrb = '0; m_wlast = 0; m_bready = 0;
    m_arvalid = 0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_rready = 0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0;
    dec_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", m_arready, 0);
    chk("rst_awready", m_awready, 0);
    chk("rst_wready", m_wready, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("rst_fault", access_fault, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (rv[k]) do_read(rv[k]);

    do_write(32'h2000_0000, 4, -1);
    do_write(32'h8000_0100, 2, 2);

    fork
      do_write(32'h1000_0004, 2, 1);
      do_read('{32'h0200_BFF8, 8'd1, 0, RESP_OKAY});
    join

    // Reset while the second of four read beats is on the bus.
    @(negedge clk);
    m_arvalid = 1'b1; m_araddr = 32'h8000_0020; m_arlen = 8'd3; m_arsize = SIZE_1B;
    @(negedge clk);
    s_arready[2] = 1'b1;
    @(negedge clk);
    m_arvalid = 1'b0; s_arready = '0; m_rready = 1'b1;
    s_rvalid = 3'b100; s_rdata[95:64] = 32'h1111_0000; s_rlast = '0;
    @(negedge clk);
    s_rdata[95:64] = 32'h1111_0001;
    #1;
    chk("rst_mid_pre_rvalid", m_rvalid, 1);
    reset = 1'b0;
    #1;
    chk("rst_mid_rvalid", m_rvalid, 0);
    chk("rst_mid_rready", s_rready, 0);
    chk("rst_mid_arready", m_arready, 0);
    chk("rst_mid_s_arvalid", s_arvalid, 0);
    chk("rst_mid_fault", access_fault, 0);
    @(negedge clk);
    s_rvalid = '0; s_rdata = '0; m_rready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    do_read('{32'h8000_0000, 8'd3, 2, RESP_OKAY});

    dec_addr = 32'h8000_1234;
    #1;
    chk("ovl_hit", dec_hit, 1);
    chk("ovl_idx", dec_idx, 0);
    dec_addr = 32'h4000_0000;
    #1;
    chk("ovl_miss", dec_hit, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
